// File: rtl/ovf_exc_pkg.sv
// Shared definitions for the overflow exception sequencer: FSM states
// and the default datapath width and exception vector.
package ovf_exc_pkg;

  localparam int          DEF_XLEN       = 32;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_0180;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HANDLER = 2'd1,
    DRAIN   = 2'd2
  } exc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with an asynchronous active-low clear.
// The count holds at all-ones once it gets there.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Advance on each increment request unless already at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ovf_exc_ctrl.sv
// Arithmetic-overflow exception sequencer for the 5-stage pipeline.
// A trapping add/sub that overflows in EX is killed along with the younger
// stages, its PC is captured, and fetch is redirected to the handler. ERET
// in MEM returns to EPC+4, followed by a short window with traps masked.
// Optional build macro: EXC_COUNT_EN enables the saturating trap counter;
// without it exc_count is tied to zero and no counter flops are built.
module ovf_exc_ctrl
  import ovf_exc_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] HANDLER_PC   = DEF_HANDLER_PC,
  parameter int              DRAIN_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_ovf_en,
  input  logic             ex_ovf,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             mem_eret,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  epc,
  output logic             cause_ovf,
  output logic             in_handler,
  output logic             double_fault,
  output logic [CNT_W-1:0] exc_count
);

  // Drain counter is loaded with DRAIN_CYCLES-1 so that it reaches zero
  // on the last masked cycle; 3 bits cover the legal range 1..7.
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  exc_state_e      state_q;
  logic [XLEN-1:0] epc_q;
  logic            cause_q;
  logic            in_handler_q;
  logic            double_fault_q;
  logic [2:0]      drain_q;

  logic trap;
  logic eret_go;
  logic take_trap;
  logic take_eret;
  logic flush_all;

  // A stalled EX instruction is held, so neither a trap nor an ERET may act
  // until the stall drops; the condition is simply re-evaluated each cycle.
  assign trap      = ex_valid & ex_ovf_en & ex_ovf & ~stall;
  assign eret_go   = mem_eret & ~stall;
  assign take_trap = (state_q == IDLE) & trap;
  assign take_eret = (state_q == HANDLER) & eret_go;
  assign flush_all = take_trap | take_eret;

  assign flush_if_id  = flush_all;
  assign flush_id_ex  = flush_all;
  assign flush_ex_mem = flush_all;
  assign pc_redirect  = flush_all;
  assign redirect_pc  = (state_q == IDLE) ? HANDLER_PC : (epc_q + XLEN'(4));

  assign epc          = epc_q;
  assign cause_ovf    = cause_q;
  assign in_handler   = in_handler_q;
  assign double_fault = double_fault_q;

  // Exception FSM: trap capture, handler residency, post-ERET drain window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      epc_q          <= '0;
      cause_q        <= 1'b0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
      drain_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trap) begin
            epc_q        <= ex_pc;
            cause_q      <= 1'b1;
            in_handler_q <= 1'b1;
            state_q      <= HANDLER;
          end
        end
        HANDLER: begin
          if (trap) begin
            double_fault_q <= 1'b1;
          end
          if (eret_go) begin
            cause_q      <= 1'b0;
            in_handler_q <= 1'b0;
            drain_q      <= DRAIN_INIT;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_q == 3'd0) begin
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        default: begin
          state_q      <= IDLE;
          in_handler_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_exc_count (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (take_trap),
    .count_o(exc_count)
  );
`else
  assign exc_count = '0;
`endif

endmodule
